// File: rtl/grover_diffusion_stage.sv
// grover_diffusion_stage: Grover inversion-about-mean over one complex amplitude vector.
// Define GROVER_ORACLE_EN to negate the marked amplitude (saturated) as the vector is captured.
module grover_diffusion_stage #(
   parameter int sample_size    = 4,
   parameter int complexnum_bit = 24
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic signed [complexnum_bit-1:0] in [sample_size],
   input  logic [$clog2(sample_size)-1:0]   marked_idx,
   output logic                             busy,
   output logic signed [complexnum_bit-1:0] out [sample_size],
   output logic                             out_valid
);
   localparam int H  = complexnum_bit / 2;
   localparam int L  = $clog2(sample_size);
   localparam int AW = H + L;

   typedef enum logic [2:0] {IDLE, SUM, MEAN, APPLY, DONE} state_t;

   state_t                           state_q, state_d;
   logic [L-1:0]                     idx_q, idx_d;
   logic [AW-1:0]                    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic [H-1:0]                     mean_re_q, mean_re_d, mean_im_q, mean_im_d;
   logic signed [complexnum_bit-1:0] buf_q [sample_size];
   logic signed [complexnum_bit-1:0] buf_d [sample_size];
   logic signed [complexnum_bit-1:0] out_q [sample_size];
   logic signed [complexnum_bit-1:0] out_d [sample_size];
   logic                             busy_q, busy_d, out_valid_q, out_valid_d;
   logic [H-1:0]                     cur_re, cur_im;
   logic                             last;

   function automatic logic [H+1:0] ext(input logic [H-1:0] x);
      return {{2{x[H-1]}}, x};
   endfunction

   // In range when the top three bits agree; otherwise clamp toward the sign.
   function automatic logic [H-1:0] sat(input logic [H+1:0] v);
      return (v[H+1:H-1] == 3'b000 || v[H+1:H-1] == 3'b111) ? v[H-1:0] : {v[H+1], {(H-1){~v[H+1]}}};
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_re_d  = acc_re_q;
      acc_im_d  = acc_im_q;
      mean_re_d = mean_re_q;
      mean_im_d = mean_im_q;
      buf_d     = buf_q;
      out_d     = out_q;
      cur_re    = buf_q[idx_q][complexnum_bit-1:H];
      cur_im    = buf_q[idx_q][H-1:0];
      last      = idx_q == L'(sample_size - 1);
      unique case (state_q)
         IDLE: if (start) begin
            state_d  = SUM;
            idx_d    = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            for (int k = 0; k < sample_size; k++) begin
               buf_d[k] = in[k];
`ifdef GROVER_ORACLE_EN
               if (marked_idx == L'(k))
                  buf_d[k] = {sat(-ext(in[k][complexnum_bit-1:H])), sat(-ext(in[k][H-1:0]))};
`endif
            end
         end
         SUM: begin
            acc_re_d = acc_re_q + {{L{cur_re[H-1]}}, cur_re};
            acc_im_d = acc_im_q + {{L{cur_im[H-1]}}, cur_im};
            idx_d    = idx_q + 1'b1;
            state_d  = last ? MEAN : SUM;
         end
         MEAN: begin
            mean_re_d = acc_re_q[AW-1:L];
            mean_im_d = acc_im_q[AW-1:L];
            state_d   = APPLY;
         end
         APPLY: begin
            out_d[idx_q] = {sat({mean_re_q[H-1], mean_re_q, 1'b0} - ext(cur_re)),
                            sat({mean_im_q[H-1], mean_im_q, 1'b0} - ext(cur_im))};
            idx_d        = idx_q + 1'b1;
            state_d      = last ? DONE : APPLY;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d      = state_d != IDLE;
      out_valid_d = state_q == DONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         mean_re_q   <= '0;
         mean_im_q   <= '0;
         buf_q       <= '{default: '0};
         out_q       <= '{default: '0};
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         mean_re_q   <= mean_re_d;
         mean_im_q   <= mean_im_d;
         buf_q       <= buf_d;
         out_q       <= out_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
endmodule

// File: tb/tb_grover_diffusion_stage.sv
// tb_grover_diffusion_stage: directed and random vectors against an arithmetic reference,
// with cycle-exact busy/out_valid timing, ignored restarts and a mid-operation reset.
module tb_grover_diffusion_stage;
   localparam int N  = 4;
   localparam int CB = 24;
   localparam int H  = 12;

   logic                 clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic signed [CB-1:0] din [N];
   logic [1:0]           mk_idx;
   logic                 busy, out_valid;
   logic signed [CB-1:0] dout [N];

   int          total = 0, bad = 0;
   int          vre[N], vim[N], mk;
   logic [CB-1:0] exp_out[N], prev_out[N];

   always #5 clk = ~clk;

   grover_diffusion_stage #(.sample_size(N), .complexnum_bit(CB)) dut (
      .clk(clk), .rst(rst), .start(start), .in(din), .marked_idx(mk_idx),
      .busy(busy), .out(dout), .out_valid(out_valid)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return v > 2047 ? 2047 : (v < -2048 ? -2048 : v);
   endfunction

   function automatic int floor_div(input int a, input int b);
      int q = a / b;
      if (a % b != 0 && a < 0) q--;
      return q;
   endfunction

   function automatic int rv();
      case ($urandom_range(0, 3))
         0:       return -2048;
         1:       return 2047;
         default: return int'($urandom_range(0, 4095)) - 2048;
      endcase
   endfunction

   function automatic void model();
      int br[N], bi[N];
      int sr = 0, si = 0, mr, mi;
      for (int k = 0; k < N; k++) begin
         br[k] = vre[k];
         bi[k] = vim[k];
      end
`ifdef GROVER_ORACLE_EN
      br[mk] = clamp(-vre[mk]);
      bi[mk] = clamp(-vim[mk]);
`endif
      for (int k = 0; k < N; k++) begin
         sr += br[k];
         si += bi[k];
      end
      mr = floor_div(sr, N);
      mi = floor_div(si, N);
      for (int k = 0; k < N; k++)
         exp_out[k] = {H'(clamp(2 * mr - br[k])), H'(clamp(2 * mi - bi[k]))};
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) din[k] = {H'(vre[k]), H'(vim[k])};
      mk_idx = 2'(mk);
   endtask

   task automatic scramble();
      for (int k = 0; k < N; k++) din[k] = CB'($urandom);
      mk_idx = 2'($urandom);
   endtask

   task automatic run_vector(input string tag);
      model();
      drive();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         check({tag, "_busy"}, busy, e < 10);
         check({tag, "_valid"}, out_valid, e == 10);
         if (e == 5)
            for (int k = 0; k < N; k++) check({tag, "_hold"}, dout[k][CB-1:0], prev_out[k]);
         if (e == 10)
            for (int k = 0; k < N; k++) check({tag, "_out"}, dout[k][CB-1:0], exp_out[k]);
         if (e == 2) begin
            scramble();
            start = 1'b1;
         end
         if (e == 3) start = 1'b0;
      end
      prev_out = exp_out;
   endtask

   task automatic reset_mid();
      for (int k = 0; k < N; k++) begin
         vre[k] = rv();
         vim[k] = rv();
      end
      drive();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      for (int k = 0; k < N; k++) check("rst_out", dout[k][CB-1:0], '0);
      #1 rst = 1'b0;
      for (int e = 7; e <= 12; e++) begin
         @(posedge clk); #1;
         check("rst_novalid", out_valid, 1'b0);
         check("rst_idle", busy, 1'b0);
      end
      for (int k = 0; k < N; k++) prev_out[k] = '0;
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         din[k]      = '0;
         prev_out[k] = '0;
      end
      mk_idx = '0;
      #1 rst = 1'b1;
      #11;
      check("reset_busy", busy, 1'b0);
      check("reset_valid", out_valid, 1'b0);
      for (int k = 0; k < N; k++) check("reset_out", dout[k][CB-1:0], '0);
      rst = 1'b0;
      @(posedge clk); #1;

      mk = 2;
      for (int k = 0; k < N; k++) begin
         vre[k] = 512;
         vim[k] = -300;
      end
      run_vector("flat");

      mk = 0;
      vre = '{2047, 2047, 2047, -2048};
      vim = '{0, 0, 0, 0};
      run_vector("sat");

      mk = 3;
      vre = '{-1, 0, 0, 0};
      run_vector("floor");

      reset_mid();
      mk = 1;
      vre = '{100, -7, 2047, -2048};
      vim = '{-2048, -2048, 5, 33};
      run_vector("after_rst");

      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < N; k++) begin
            vre[k] = rv();
            vim[k] = rv();
         end
         mk = int'($urandom_range(0, N - 1));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_vector("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
